step_sched: RTL and testbench

Step pulse scheduler that sequences the step output stage. It accepts queued moves over the Wishbone register bus, where each move is a direction, a step count and a step interval. It generates timed `step_pulse` and `dir` signals that feed the pin output stage, which applies polarity and shutdown masking. A 4-entry move FIFO lets software queue moves ahead so consecutive moves run without bus-timing gaps.

---
 rtl/step_sched.sv | 167 ++++++++++++++++
 tb/tb_step_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_sched.sv
// Step pulse scheduler: dequeues moves (dir, count, interval) from a small FIFO
// and emits timed step pulses plus direction to the pin output stage.
//
// state | meaning
// IDLE  | no move executing, waiting for a queued move
// WAIT  | timer counting down to the next step rise
// PULSE | step_pulse high, pulse width counter running
module step_sched #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        step_pulse,
  output logic        dir,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, PULSE} state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [LW-1:0]   level;
  logic            overflow;
  logic [7:0]      pulse_ticks;
  logic [7:0]      pcnt;
  logic [10:0]     remaining;
  logic [19:0]     timer;
  logic [19:0]     interval_r;
  logic            busy;

  logic            wr_en, enq, set_pt, flush;
  logic            fifo_empty, fifo_full, do_enq, deq, start;
  logic            rise, pulse_done, move_end;
  logic [31:0]     head;
  logic            head_dir;
  logic [10:0]     head_cnt;
  logic [19:0]     head_iv, first_timer, period_val;
  logic [8:0]      pt_p1;

  assign wr_en  = wb_cyc_i && wb_stb_i && wb_we_i;
  assign enq    = wr_en && (wb_adr_i == 4'd0);
  assign set_pt = wr_en && (wb_adr_i == 4'd1);
  assign flush  = wr_en && (wb_adr_i == 4'd3);

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign head       = mem[rd_ptr];
  assign head_dir   = head[31];
  assign head_cnt   = head[30:20];
  assign head_iv    = head[19:0];

  assign rise       = (state == WAIT) && (timer == 20'd1);
  assign pulse_done = (state == PULSE) && (pcnt == 8'd1);
  assign move_end   = pulse_done && (remaining == '0);
  assign deq        = !fifo_empty && !flush && ((state == IDLE) || move_end);
  // zero-count moves are consumed from the FIFO but never started
  assign start      = deq && (head_cnt != '0);
  assign do_enq     = enq && (!fifo_full || deq);

  assign first_timer = (head_iv == '0) ? 20'd1 : head_iv;
  assign pt_p1       = {1'b0, pulse_ticks} + 9'd1;
  assign period_val  = (interval_r > {11'd0, pt_p1}) ? interval_r : {11'd0, pt_p1};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = WAIT;
      WAIT:  if (rise) state_nxt = PULSE;
      PULSE: begin
        if (pulse_done) begin
          if (remaining != '0) state_nxt = WAIT;
          else if (start)      state_nxt = WAIT;
          else                 state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    busy     = (state != IDLE);
    wb_ack_o = 1'b1;
    case (wb_adr_i)
      4'd0:    wb_dat_o = {23'd0, dir, 3'd0, overflow, busy, 3'(level)};
      4'd1:    wb_dat_o = {21'd0, remaining};
      default: wb_dat_o = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= wb_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      pulse_ticks <= 8'd2;
      pcnt        <= '0;
      remaining   <= '0;
      timer       <= '0;
      interval_r  <= '0;
      dir         <= 1'b0;
      step_pulse  <= 1'b0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      remaining  <= '0;
      step_pulse <= 1'b0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + AW'(1);
      if (enq && !do_enq) overflow <= 1'b1;
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      if (do_enq && !deq)      level <= level + LW'(1);
      else if (!do_enq && deq) level <= level - LW'(1);
      if (set_pt) pulse_ticks <= (wb_dat_i[7:0] == 8'd0) ? 8'd1 : wb_dat_i[7:0];

      // one down-counter serves both the first interval and the step period
      case (state)
        WAIT: begin
          if (timer == 20'd1) begin
            step_pulse <= 1'b1;
            remaining  <= remaining - 11'd1;
            timer      <= period_val;
            pcnt       <= pulse_ticks;
          end else begin
            timer <= timer - 20'd1;
          end
        end
        PULSE: begin
          timer <= timer - 20'd1;
          if (pcnt == 8'd1) step_pulse <= 1'b0;
          else              pcnt <= pcnt - 8'd1;
        end
        default: ;
      endcase

      if (start) begin
        dir        <= head_dir;
        remaining  <= head_cnt;
        timer      <= first_timer;
        interval_r <= head_iv;
      end
    end
  end

endmodule

// File: tb/tb_step_sched.sv
// Directed bench for step_sched: expected pulse edges are queued as moves are
// written and compared against edges recorded from the DUT.
module tb_step_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step_pulse, dir;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]  wb_adr_i = 4'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  step_sched #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .step_pulse(step_pulse), .dir(dir),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int exp_rise[$], exp_fall[$], obs_rise[$], obs_fall[$];
  logic prev_sp = 1'b0;

  always @(negedge clk) begin
    if (step_pulse && !prev_sp) obs_rise.push_back(cyc);
    if (!step_pulse && prev_sp) obs_fall.push_back(cyc);
    prev_sp = step_pulse;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mv(input logic d, input int cnt, input int iv);
    logic [10:0] c;
    logic [19:0] i;
    c = 11'(cnt);
    i = 20'(iv);
    return {d, c, i};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d, output int w);
    @(negedge clk);
    wb_adr_i = a; wb_dat_i = d;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    @(posedge clk);
    #1;
    w = cyc;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = 4'd0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
    wb_adr_i = a;
    #1;
    d = wb_dat_o;
    wb_adr_i = 4'd0;
    #1;
  endtask

  task automatic poll_idle(input int budget, output int drop_cyc, output int dir_cyc);
    drop_cyc = -1;
    dir_cyc  = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (dir && dir_cyc < 0) dir_cyc = cyc;
      if (!wb_dat_o[3]) begin
        drop_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_rise(input int budget, output int rc);
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (step_pulse) begin
        rc = cyc;
        break;
      end
    end
  endtask

  task automatic sb_compare(input string tag);
    int e, o;
    while (exp_rise.size() > 0) begin
      e = exp_rise.pop_front();
      o = (obs_rise.size() > 0) ? obs_rise.pop_front() : -1;
      check({tag, "_rise"}, o, e);
    end
    while (exp_fall.size() > 0) begin
      e = exp_fall.pop_front();
      o = (obs_fall.size() > 0) ? obs_fall.pop_front() : -1;
      check({tag, "_fall"}, o, e);
    end
    check({tag, "_extra_edges"}, obs_rise.size() + obs_fall.size(), 0);
  endtask

  task automatic clear_obs();
    obs_rise.delete();
    obs_fall.delete();
  endtask

  initial begin
    int w, w2, e0, drop, dc, rc, busy_seen;
    logic [31:0] rd;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_step_pulse", step_pulse, 1'b0);
    check("rst_dir", dir, 1'b0);
    wb_read(4'd0, rd); check("rst_status", rd, 32'd0);
    wb_read(4'd1, rd); check("rst_remaining", rd, 32'd0);
    check("rst_ack", wb_ack_o, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_obs();

    // single move with default pulse width
    wb_write(4'd0, mv(1'b1, 3, 10), w);
    e0 = w + 1;
    for (int k = 0; k < 3; k++) begin
      exp_rise.push_back(e0 + 10 + 10 * k);
      exp_fall.push_back(e0 + 12 + 10 * k);
    end
    @(posedge clk);
    poll_idle(200, drop, dc);
    check("t1_busy_drop", drop, e0 + 32);
    check("t1_dir_cycle", dc, e0);
    wb_read(4'd0, rd); check("t1_level", {29'd0, rd[2:0]}, 32'd0);
    sb_compare("t1");

    // wider pulse forces period to pulse_ticks+1
    wb_write(4'd1, 32'd4, w);
    wb_write(4'd0, mv(1'b0, 3, 2), w);
    e0 = w + 1;
    for (int k = 0; k < 3; k++) begin
      exp_rise.push_back(e0 + 2 + 5 * k);
      exp_fall.push_back(e0 + 6 + 5 * k);
    end
    @(posedge clk);
    poll_idle(200, drop, dc);
    check("t2_busy_drop", drop, e0 + 16);
    sb_compare("t2");

    // back-to-back moves
    wb_write(4'd0, mv(1'b0, 2, 8), w);
    wb_write(4'd0, mv(1'b1, 1, 3), w2);
    e0 = w + 1;
    exp_rise.push_back(e0 + 8);  exp_fall.push_back(e0 + 12);
    exp_rise.push_back(e0 + 16); exp_fall.push_back(e0 + 20);
    exp_rise.push_back(e0 + 23); exp_fall.push_back(e0 + 27);
    poll_idle(200, drop, dc);
    check("t3_busy_drop", drop, e0 + 27);
    check("t3_dir_toggle", dc, e0 + 20);
    sb_compare("t3");

    // overflow and flush mid-pulse
    wb_write(4'd0, mv(1'b0, 5, 1000), w);
    e0 = w + 1;
    for (int k = 0; k < 5; k++) wb_write(4'd0, mv(1'b1, 1, 5), w2);
    @(negedge clk); #1;
    wb_read(4'd0, rd); check("t4_status_full", rd, 32'h1C);
    wait_rise(1100, rc);
    check("t4_first_rise", rc, e0 + 1000);
    wb_write(4'd3, 32'd0, w);
    check("t4_flush_pulse", step_pulse, 1'b0);
    wb_read(4'd0, rd); check("t4_status_flushed", rd, 32'd0);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    wb_read(4'd0, rd); check("t4_status_later", rd, 32'd0);
    check("t4_rise_count", obs_rise.size(), 1);
    clear_obs();

    // zero-count move is discarded
    wb_write(4'd0, mv(1'b1, 0, 5), w);
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (wb_dat_o[3]) busy_seen++;
    end
    check("t5_busy_seen", busy_seen, 0);
    check("t5_dir", dir, 1'b0);
    check("t5_rises", obs_rise.size(), 0);
    wb_read(4'd0, rd); check("t5_status", rd, 32'd0);

    // reset mid-pulse
    wb_write(4'd0, mv(1'b1, 2, 3), w);
    wait_rise(20, rc);
    check("t6_rise", rc, w + 4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_pulse", step_pulse, 1'b0);
    check("t6_rst_dir", dir, 1'b0);
    wb_read(4'd0, rd); check("t6_rst_status", rd, 32'd0);
    wb_read(4'd1, rd); check("t6_rst_remaining", rd, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_obs();

    // pulse_ticks back to its reset value of 2
    wb_write(4'd0, mv(1'b0, 1, 2), w);
    exp_rise.push_back(w + 3);
    exp_fall.push_back(w + 5);
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    sb_compare("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
